miter_skew_monitor: RTL and testbench

- Parametrised observer that sits beside a two-copy miter (two identical crypto cores driven from one clock/reset).
- Compares the output streams of copy 1 and copy 2 each enabled cycle and flags the first divergence.
- Copy 1 can be delayed by a programmable skew before comparison, so copies started at different times, or with a timing variant, can still be checked.
- Latches the divergence cycle and the differing-bit mask, then holds them for the formal and simulation harnesses.

---
 rtl/miter_skew_monitor.sv | 84 ++++++++
 tb/tb_miter_skew_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/miter_skew_monitor.sv
// miter_skew_monitor: compares the two copies of a miter, with copy 1 optionally delayed,
// and latches the first divergence (cycle index and differing-bit mask).
module miter_skew_monitor #(
    parameter int WIDTH    = 37,
    parameter int MAX_SKEW = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             arm_i,
    input  logic             clear_i,
    input  logic [3:0]       skew_i,
    input  logic [WIDTH-1:0] mask_i,
    input  logic [WIDTH-1:0] data1_i,
    input  logic [WIDTH-1:0] data2_i,
    output logic [1:0]       state_o,
    output logic             mismatch_o,
    output logic [WIDTH-1:0] diff_o,
    output logic [CNT_W-1:0] div_cycle_o,
    output logic [CNT_W-1:0] cmp_count_o
);
    typedef enum logic [1:0] {IDLE, FILL, CHECK, DIVERGED} state_t;
    state_t state;
    logic [3:0] skew, fill_cnt, skew_clamped;
    logic [WIDTH-1:0] dl [MAX_SKEW];
    logic [WIDTH-1:0] d1_del, diff;
    // dl[k] holds data1_i from k+1 enabled cycles ago; skew 0 bypasses the line
    always_comb begin
        d1_del = data1_i;
        for (int i = 0; i < MAX_SKEW; i++)
            if (skew == 4'(i + 1)) d1_del = dl[i];
    end
    assign diff = (d1_del ^ data2_i) & mask_i;
    assign skew_clamped = (skew_i > 4'(MAX_SKEW)) ? 4'(MAX_SKEW) : skew_i;
    assign state_o = state;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_SKEW; i++) dl[i] <= '0;
        end else if (en_i) begin
            dl[0] <= data1_i;
            for (int i = 1; i < MAX_SKEW; i++) dl[i] <= dl[i-1];
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            skew        <= '0;
            fill_cnt    <= '0;
            mismatch_o  <= 1'b0;
            diff_o      <= '0;
            div_cycle_o <= '0;
            cmp_count_o <= '0;
        end else if (clear_i) begin
            state <= IDLE;
        end else if (en_i) begin
            case (state)
                IDLE: if (arm_i) begin
                    skew        <= skew_clamped;
                    fill_cnt    <= '0;
                    mismatch_o  <= 1'b0;
                    diff_o      <= '0;
                    div_cycle_o <= '0;
                    cmp_count_o <= '0;
                    state       <= (skew_clamped == 4'd0) ? CHECK : FILL;
                end
                FILL: begin
                    if (fill_cnt == skew - 4'd1) state <= CHECK;
                    else fill_cnt <= fill_cnt + 4'd1;
                end
                CHECK: begin
                    if (cmp_count_o != '1) cmp_count_o <= cmp_count_o + 1'b1;
                    if (|diff) begin
                        state       <= DIVERGED;
                        mismatch_o  <= 1'b1;
                        diff_o      <= diff;
                        div_cycle_o <= cmp_count_o;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_miter_skew_monitor.sv
// tb_miter_skew_monitor: table vectors, directed corner sequences and random stimulus
// checked against a queue-based reference model of the skewed miter comparison.
module tb_miter_skew_monitor;
    localparam int W = 37, MS = 4, CW = 16;
    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] A = 37'h0_1234_5678;
    localparam logic [W-1:0] B = 37'h1_dead_beef;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, arm = 1'b0, clr = 1'b0;
    logic [3:0] sk = '0;
    logic [W-1:0] mask = '0, d1 = '0, d2 = '0;
    logic [1:0] state_o;
    logic mismatch_o;
    logic [W-1:0] diff_o;
    logic [CW-1:0] div_cycle_o, cmp_count_o;

    miter_skew_monitor #(.WIDTH(W), .MAX_SKEW(MS), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .en_i(en), .arm_i(arm), .clear_i(clr), .skew_i(sk),
        .mask_i(mask), .data1_i(d1), .data2_i(d2), .state_o(state_o),
        .mismatch_o(mismatch_o), .diff_o(diff_o), .div_cycle_o(div_cycle_o),
        .cmp_count_o(cmp_count_o));

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int m_state, m_skew, m_fill, m_div, m_cnt;
    logic m_mis;
    logic [W-1:0] m_diff;
    logic [W-1:0] hist [$];

    typedef struct {
        logic en, arm, clr;
        logic [3:0] sk;
        logic mfull;
        logic [W-1:0] d1, d2;
        int st, mis, cnt;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        logic [63:0] v;
        v = {$urandom, $urandom};
        return v[W-1:0];
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < MS; i++) hist.push_back('0);
        m_state = 0; m_skew = 0; m_fill = 0; m_div = 0; m_cnt = 0; m_mis = 0; m_diff = '0;
    endtask

    // Copy 1 seen through a history of enabled samples: hist[k] is k+1 en-cycles old.
    task automatic model_step();
        logic [W-1:0] tap, dd;
        if (m_skew == 0) tap = d1;
        else tap = hist[m_skew-1];
        dd = (tap ^ d2) & mask;
        if (clr) m_state = 0;
        else if (en) begin
            if (m_state == 0 && arm) begin
                m_skew = (sk > MS) ? MS : int'(sk);
                m_mis = 0; m_diff = '0; m_div = 0; m_cnt = 0; m_fill = 0;
                m_state = (m_skew == 0) ? 2 : 1;
            end else if (m_state == 1) begin
                m_fill++;
                if (m_fill == m_skew) m_state = 2;
            end else if (m_state == 2) begin
                if (dd != 0) begin
                    m_state = 3; m_mis = 1; m_diff = dd; m_div = m_cnt;
                end
                if (m_cnt < 2**CW - 1) m_cnt++;
            end
        end
        if (en) begin
            hist.push_front(d1);
            void'(hist.pop_back());
        end
    endtask

    task automatic check_model();
        chk("state", 64'(state_o), 64'(m_state));
        chk("mismatch", 64'(mismatch_o), 64'(m_mis));
        chk("diff", 64'(diff_o), 64'(m_diff));
        chk("div_cycle", 64'(div_cycle_o), 64'(m_div));
        chk("cmp_count", 64'(cmp_count_o), 64'(m_cnt));
    endtask

    task automatic step(input logic e, input logic a, input logic c, input logic [3:0] s,
                        input logic [W-1:0] m, input logic [W-1:0] x, input logic [W-1:0] y);
        en = e; arm = a; clr = c; sk = s; mask = m; d1 = x; d2 = y;
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        en = 0; arm = 0; clr = 0;
        rst = 1;
        model_reset();
        #2;
        check_model();
        @(negedge clk);
        rst = 0;
    endtask

    // Continuous stream: 10 idle cycles, arm, then fill and ncmp compare cycles;
    // copy 2 is copy 1 delayed by lag.
    task automatic run_stream(input logic [3:0] s, input int lag, input int ncmp);
        logic [W-1:0] st [$];
        int total;
        total = 11 + ((s > MS) ? MS : int'(s)) + ncmp;
        for (int i = 0; i < total; i++) st.push_back(rnd());
        for (int i = 0; i < total; i++)
            step(1, i == 10, 0, s, ONES, st[i], (i >= lag) ? st[i-lag] : '0);
    endtask

    initial begin
        model_reset();
        #2;
        do_reset();

        // Table vectors
        tbl[0]  = '{1, 1, 0, 4'd0, 1, A, A,       2, 0, 0};
        tbl[1]  = '{1, 0, 0, 4'd0, 1, A, A,       2, 0, 1};
        tbl[2]  = '{1, 0, 0, 4'd0, 1, B, B,       2, 0, 2};
        tbl[3]  = '{0, 0, 0, 4'd0, 1, A, B,       2, 0, 2};
        tbl[4]  = '{1, 0, 0, 4'd0, 0, A, B,       2, 0, 3};
        tbl[5]  = '{1, 0, 0, 4'd0, 1, A, A ^ 37'h8, 3, 1, 4};
        tbl[6]  = '{1, 1, 0, 4'd0, 1, A, B,       3, 1, 4};
        tbl[7]  = '{1, 1, 1, 4'd0, 1, A, B,       0, 1, 4};
        tbl[8]  = '{0, 1, 0, 4'd0, 1, A, B,       0, 1, 4};
        tbl[9]  = '{1, 1, 0, 4'd2, 1, A, B,       1, 0, 0};
        tbl[10] = '{1, 0, 0, 4'd2, 1, B, A,       1, 0, 0};
        tbl[11] = '{1, 0, 0, 4'd2, 1, A, B,       2, 0, 0};
        for (int i = 0; i < 12; i++) begin
            step(tbl[i].en, tbl[i].arm, tbl[i].clr, tbl[i].sk, tbl[i].mfull ? ONES : '0,
                 tbl[i].d1, tbl[i].d2);
            chk($sformatf("tbl%0d_state", i), 64'(state_o), 64'(tbl[i].st));
            chk($sformatf("tbl%0d_mis", i), 64'(mismatch_o), 64'(tbl[i].mis));
            chk($sformatf("tbl%0d_cnt", i), 64'(cmp_count_o), 64'(tbl[i].cnt));
        end
        chk("tbl_div_cycle", 64'(div_cycle_o), 64'd0);

        // Reset mid-CHECK after 5 compares takes effect before the next edge
        do_reset();
        step(1, 1, 0, 4'd0, ONES, A, A);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 4'd0, ONES, B, B);
        chk("pre_reset_cnt", 64'(cmp_count_o), 64'd5);
        rst = 1;
        model_reset();
        #2;
        check_model();
        chk("async_reset_state", 64'(state_o), 64'd0);
        chk("async_reset_cnt", 64'(cmp_count_o), 64'd0);
        @(negedge clk);
        rst = 0;

        // skew 0: 10 equal samples, then bit 3 flipped
        step(1, 1, 0, 4'd0, ONES, A, A);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 4'd0, ONES, A, A);
        step(1, 0, 0, 4'd0, ONES, A, A ^ 37'h8);
        chk("flip_state", 64'(state_o), 64'd3);
        chk("flip_div", 64'(div_cycle_o), 64'd10);
        chk("flip_diff", 64'(diff_o), 64'h8);
        chk("flip_cnt", 64'(cmp_count_o), 64'd11);
        chk("flip_mis", 64'(mismatch_o), 64'd1);

        // Skewed streams, including clamping of skew 9 to MAX_SKEW
        do_reset();
        run_stream(4'd2, 2, 20);
        chk("skew2_mis", 64'(mismatch_o), 64'd0);
        chk("skew2_cnt", 64'(cmp_count_o), 64'd20);
        do_reset();
        run_stream(4'd1, 2, 20);
        chk("skew1_mis", 64'(mismatch_o), 64'd1);
        chk("skew1_div", 64'(div_cycle_o), 64'd0);
        chk("skew1_cnt", 64'(cmp_count_o), 64'd1);
        do_reset();
        run_stream(4'd9, 4, 20);
        chk("skew9_lag4_mis", 64'(mismatch_o), 64'd0);
        chk("skew9_lag4_cnt", 64'(cmp_count_o), 64'd20);
        do_reset();
        run_stream(4'd9, 9, 20);
        chk("skew9_lag9_state", 64'(state_o), 64'd3);
        chk("skew9_lag9_div", 64'(div_cycle_o), 64'd0);

        // en low with differing data present: hold, then catch on first enabled cycle
        do_reset();
        step(1, 1, 0, 4'd0, ONES, A, A);
        step(1, 0, 0, 4'd0, ONES, A, A);
        step(1, 0, 0, 4'd0, ONES, B, B);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 4'd0, ONES, A, B);
            chk("enlow_state", 64'(state_o), 64'd2);
            chk("enlow_cnt", 64'(cmp_count_o), 64'd2);
        end
        step(1, 0, 0, 4'd0, ONES, A, B);
        chk("enlow_catch_state", 64'(state_o), 64'd3);
        chk("enlow_catch_div", 64'(div_cycle_o), 64'd2);
        chk("enlow_catch_diff", 64'(diff_o), 64'(A ^ B));

        // Random stimulus against the model
        do_reset();
        begin
            logic [W-1:0] rq [$];
            logic [W-1:0] x, y;
            int lag;
            lag = 0;
            for (int i = 0; i < 8; i++) rq.push_back(rnd());
            for (int i = 0; i < 600; i++) begin
                if ($urandom_range(0, 15) == 0) lag = $urandom_range(0, 5);
                x = ($urandom_range(0, 3) == 0) ? A : rnd();
                y = (lag == 0) ? x : rq[lag-1];
                if ($urandom_range(0, 29) == 0) y = y ^ (37'h1 << $urandom_range(0, W-1));
                step($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 24) == 0, 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 3) == 0) ? rnd() : ONES, x, y);
                rq.push_front(x);
                void'(rq.pop_back());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
